sma_gen: RTL
============

SMA_GEN -- requirements
Module: sma_gen

Interface
- REQ-001: Parameter DATA_W, default 16, sample and result width, signed two's complement, range 2..32.
- REQ-002: Parameter LOG2_DEPTH, default 2, log2 of window length; DEPTH = 2**LOG2_DEPTH, range 1..8.
- REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004: rst  input  1  asynchronous, active-high reset.
- REQ-005: clear  input  1  synchronous flush of window state.
- REQ-006: in_valid  input  1  x carries a new sample this cycle.
- REQ-007: x  input  DATA_W signed  input sample.
- REQ-008: out_valid  output  1  y updated this cycle; one-cycle pulse per accepted sample.
- REQ-009: y  output  DATA_W signed  registered moving average.
- REQ-010: primed  output  1  window holds DEPTH real samples since the last reset or clear.

Function
- REQ-011: History is a DEPTH-entry circular buffer with write pointer wptr (LOG2_DEPTH bits); the entry at wptr is the oldest sample.
- REQ-012: Running accumulator acc is DATA_W+LOG2_DEPTH bits wide, signed; on an accepted sample, acc_next = acc + x - hist[wptr], sign-extended, no overflow possible.
- REQ-013: On an accepted sample, hist[wptr] <= x and wptr <= wptr+1, wrapping from DEPTH-1 to 0.
- REQ-014: y <= acc_next >>> LOG2_DEPTH, truncated to DATA_W; the result always fits, with no saturation logic.
- REQ-015: Latency is one cycle: out_valid rises in the cycle after in_valid and y is valid with it.
- REQ-016: Without in_valid: acc, hist, wptr and y hold, and out_valid is 0.
- REQ-017: Back-to-back in_valid is accepted every cycle (throughput 1 sample/clk).
- REQ-018: During warm-up, unfilled entries count as zero: y = (sum of received samples)/DEPTH.
- REQ-019: Fill counter saturates at DEPTH; primed asserts in the same cycle as the out_valid of the DEPTH-th sample.
- REQ-020: On clear, hist, acc, wptr, fill counter, primed and y go to zero next cycle, and out_valid is 0.
- REQ-021: When clear and in_valid occur together, clear wins and the sample is discarded.

Reset
- REQ-022: While rst is high: y=0, out_valid=0, primed=0, acc=0, wptr=0, fill=0, all hist entries 0; effect is immediate, without a clock.
- REQ-023: Reset asserted mid-stream discards all window state; the first sample after deassertion behaves as sample 1 of REQ-018.

Configuration
- REQ-024: Macro SMA_GEN_ROUND_EN defined: y = (acc_next + 2**(LOG2_DEPTH-1)) >>> LOG2_DEPTH, i.e. round half up.
- REQ-025: SMA_GEN_ROUND_EN undefined: plain arithmetic shift (floor, toward minus infinity); no rounding adder is present.

Structure
- REQ-026: Package sma_gen_pkg holds the default DATA_W/LOG2_DEPTH constants and the accumulator-width function (DATA_W+LOG2_DEPTH).
- REQ-027: Sub-module sma_gen_hist holds the circular buffer, wptr and fill counter, and outputs the oldest entry and primed; sma_gen holds acc, the divide and the output registers.

Verification (DATA_W=16, LOG2_DEPTH=2 unless noted)
- REQ-028: Samples 4,8,12,16,20 back-to-back -> y 1,3,6,10,14 one cycle later each; primed rises with y=10.
- REQ-029: Single sample -1 after reset -> y=-1 without SMA_GEN_ROUND_EN; y=0 with it.
- REQ-030: Four samples 32767 then four samples -32768 -> y settles at 32767 then -32768 with no wrap.
- REQ-031: Samples 4,8 then clear together with in_valid x=100 -> out_valid 0, y=0, primed 0; next sample 8 -> y=2.
- REQ-032: rst pulsed asynchronously between clock edges mid-stream -> y, out_valid and primed go to 0 at once; stream 4,4,4,4 -> y 1,2,3,4.
- REQ-033: LOG2_DEPTH=3, in_valid every other cycle with x=8 -> y 1,2,...,8 and out_valid alternating; y holds between pulses.

Source files
------------

// File: rtl/sma_gen_pkg.sv
// Shared defaults and width helper for the sma_gen moving-average block.
// Optional rounding is selected in sma_gen by the SMA_GEN_ROUND_EN macro.
package sma_gen_pkg;

  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned LOG2_DEPTH_DEF = 2;

  // Accumulator holds the sum of DEPTH samples without overflow.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned log2_depth);
    return data_w + log2_depth;
  endfunction

endpackage

// File: rtl/sma_gen_hist.sv
// Circular sample history for sma_gen: DEPTH entries, write pointer and
// saturating fill counter. The entry at wptr is always the oldest sample.
module sma_gen_hist
  import sma_gen_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LOG2_DEPTH = LOG2_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] oldest,
  output logic                     primed
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FULL = (LOG2_DEPTH+1)'(DEPTH);

  logic signed [DATA_W-1:0] hist [DEPTH];
  logic [LOG2_DEPTH-1:0]    wptr;
  logic [LOG2_DEPTH:0]      fill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) hist[i] <= '0;
      wptr <= '0;
      fill <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) hist[i] <= '0;
      wptr <= '0;
      fill <= '0;
    end else if (push) begin
      hist[wptr] <= x;
      // pointer is exactly LOG2_DEPTH bits, so it wraps DEPTH-1 -> 0
      wptr <= wptr + 1'b1;
      if (fill != FULL) fill <= fill + 1'b1;
    end
  end

  assign oldest = hist[wptr];
  assign primed = (fill == FULL);

endmodule

// File: rtl/sma_gen.sv
// Simple moving average over 2**LOG2_DEPTH samples, one-cycle latency.
// Define SMA_GEN_ROUND_EN for round-half-up; default is floor division.
module sma_gen
  import sma_gen_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LOG2_DEPTH = LOG2_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] x,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] y,
  output logic                     primed
);

  localparam int unsigned AW = acc_width(DATA_W, LOG2_DEPTH);

  logic signed [AW-1:0]     acc;
  logic signed [AW-1:0]     acc_next;
  logic signed [DATA_W-1:0] oldest;
  logic signed [DATA_W-1:0] y_next;
  logic                     push;

  // clear wins over a coincident sample
  assign push = in_valid & ~clear;

  sma_gen_hist #(
    .DATA_W    (DATA_W),
    .LOG2_DEPTH(LOG2_DEPTH)
  ) u_hist (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .x     (x),
    .oldest(oldest),
    .primed(primed)
  );

  always_comb begin
    acc_next = acc + AW'(x) - AW'(oldest);
`ifdef SMA_GEN_ROUND_EN
    y_next = DATA_W'((acc_next + (AW'(1) <<< (LOG2_DEPTH - 1))) >>> LOG2_DEPTH);
`else
    y_next = DATA_W'(acc_next >>> LOG2_DEPTH);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      acc       <= acc_next;
      y         <= y_next;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
